// File: rtl/rv32i_types.sv
// Shared types and constants for the RV32I core.
// Holds the fetch-stage state encoding and the reset/NOP constants that the
// fetch stage uses as its parameter defaults.
package rv32i_types;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        BUFFERED = 2'd1,
        DROP     = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_RESET_VAL  = 32'h0000_0060;
    localparam logic [31:0] NOP_INSTR_VAL = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry skid buffer for the fetch stage.
// Catches an instruction that returned from memory while decode was stalled,
// so the memory response is never lost.
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   load                  capture load_pc / load_instr
//   unload                entry has been consumed; mark it empty
//   clear                 flush; mark it empty (wins over load)
//   load_pc, load_instr   entry being captured
//   valid, pc, instr      current entry contents
module fetch_skid_buffer
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    // Clear and unload both empty the entry; a flush must beat a load that
    // was computed in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= 32'h0;
            instr <= NOP_INSTR_VAL;
        end else if (clear || unload) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage of the pipelined RV32I core.
// Owns the PC, issues held read requests to instruction memory, feeds the
// IF/ID register, absorbs decode stalls with a one-entry skid buffer and
// applies branch/jump redirects, including ones that land while a memory
// request is still outstanding.
// Ports:
//   clk, rst                          clock and asynchronous active-high reset
//   imem_address, imem_read           fetch request (Moore outputs)
//   imem_resp, imem_rdata             one-cycle response strobe and data
//   stall                             decode cannot accept; IF/ID holds
//   redirect, redirect_pc             taken branch/jump target from EX
//   if_id_valid, if_id_pc,
//   if_id_instruction                 IF/ID register towards decode
module fetch_stage
    import rv32i_types::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_VAL,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_VAL
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction
);

    fetch_state_t state, next_state;
    logic [31:0]  pc, pc_next;
    logic [31:0]  drop_pc;
    logic         drop_pc_load;
    logic         ifid_load_mem, ifid_load_buf, ifid_clear;
    logic         buf_load, buf_unload, buf_clear;
    logic         buf_valid;
    logic [31:0]  buf_pc, buf_instr;

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .unload     (buf_unload),
        .clear      (buf_clear),
        .load_pc    (pc),
        .load_instr (imem_rdata),
        .valid      (buf_valid),
        .pc         (buf_pc),
        .instr      (buf_instr)
    );

    // The request is abandoned the moment reset asserts, so the read strobe
    // is gated by rst rather than waiting for the state register.
    assign imem_read    = ~rst & (state != BUFFERED);
    assign imem_address = (state == DROP) ? drop_pc : pc;

    // Next-state and datapath control. A redirect overrides everything else;
    // if it lands while a request is in flight with no response yet, the old
    // address is kept on the bus until the stale response is swallowed.
    always_comb begin
        next_state    = state;
        pc_next       = pc;
        drop_pc_load  = 1'b0;
        ifid_load_mem = 1'b0;
        ifid_load_buf = 1'b0;
        ifid_clear    = 1'b0;
        buf_load      = 1'b0;
        buf_unload    = 1'b0;
        buf_clear     = 1'b0;

        if (redirect) begin
            ifid_clear = 1'b1;
            buf_clear  = 1'b1;
            pc_next    = {redirect_pc[31:2], 2'b00};
            case (state)
                FETCH: begin
                    if (!imem_resp) begin
                        drop_pc_load = 1'b1;
                        next_state   = DROP;
                    end
                end
                BUFFERED: next_state = FETCH;
                DROP:     next_state = DROP;
                default:  next_state = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_resp) begin
                        pc_next = pc + 32'd4;
                        if (stall) begin
                            buf_load   = 1'b1;
                            next_state = BUFFERED;
                        end else begin
                            ifid_load_mem = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_clear = 1'b1;
                    end
                end
                BUFFERED: begin
                    if (!stall) begin
                        ifid_load_buf = 1'b1;
                        buf_unload    = 1'b1;
                        next_state    = FETCH;
                    end
                end
                DROP: begin
                    if (imem_resp) begin
                        next_state = FETCH;
                    end
                end
                default: next_state = FETCH;
            endcase
        end
    end

    // State, PC and drop address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= PC_RESET;
            drop_pc <= 32'h0;
        end else begin
            state <= next_state;
            pc    <= pc_next;
            if (drop_pc_load) begin
                drop_pc <= pc;
            end
        end
    end

    // IF/ID register. Whenever it is emptied the instruction is forced to the
    // NOP so decode never sees stale bits; if_id_pc is left as-is since it is
    // meaningless while invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_valid       <= 1'b0;
            if_id_pc          <= 32'h0;
            if_id_instruction <= NOP_INSTR;
        end else if (ifid_clear) begin
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
        end else if (ifid_load_mem) begin
            if_id_valid       <= 1'b1;
            if_id_pc          <= pc;
            if_id_instruction <= imem_rdata;
        end else if (ifid_load_buf) begin
            if_id_valid       <= buf_valid;
            if_id_pc          <= buf_pc;
            if_id_instruction <= buf_instr;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed walk through the main fetch,
// stall, redirect and wrap scenarios, then randomized stall/redirect/response
// traffic, all compared every cycle against a transaction-level model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] PCR = 32'h0000_0060;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_address;
    logic        imem_read;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;

    int checks   = 0;
    int failures = 0;

    // Reference model: next address to fetch, an abandoned request still
    // owed a response, an instruction parked while decode stalls, and what
    // decode currently sees.
    logic [31:0] m_pc;
    logic        m_old_busy;
    logic [31:0] m_old_addr;
    logic        h_valid;
    logic [31:0] h_pc, h_instr;
    logic        q_valid;
    logic [31:0] q_pc, q_instr;

    fetch_stage dut (
        .clk               (clk),
        .rst               (rst),
        .imem_address      (imem_address),
        .imem_read         (imem_read),
        .imem_resp         (imem_resp),
        .imem_rdata        (imem_rdata),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction)
    );

    // 10-time-unit clock, rising edges at 5, 15, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_pc       = PCR;
        m_old_busy = 1'b0;
        m_old_addr = 32'h0;
        h_valid    = 1'b0;
        h_pc       = 32'h0;
        h_instr    = NOP;
        q_valid    = 1'b0;
        q_pc       = 32'h0;
        q_instr    = NOP;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        if (redirect) begin
            q_valid = 1'b0;
            q_instr = NOP;
            if (!h_valid && !m_old_busy && !imem_resp) begin
                m_old_busy = 1'b1;
                m_old_addr = m_pc;
            end
            h_valid = 1'b0;
            m_pc    = redirect_pc & 32'hFFFF_FFFC;
        end else if (h_valid) begin
            if (!stall) begin
                q_valid = 1'b1;
                q_pc    = h_pc;
                q_instr = h_instr;
                h_valid = 1'b0;
            end
        end else if (m_old_busy) begin
            if (imem_resp) m_old_busy = 1'b0;
        end else if (imem_resp) begin
            if (stall) begin
                h_valid = 1'b1;
                h_pc    = m_pc;
                h_instr = imem_rdata;
            end else begin
                q_valid = 1'b1;
                q_pc    = m_pc;
                q_instr = imem_rdata;
            end
            m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            q_valid = 1'b0;
            q_instr = NOP;
        end
    endtask

    task automatic compareAll();
        checkOutput("imem_read", {31'b0, imem_read}, {31'b0, !h_valid});
        if (!h_valid)
            checkOutput("imem_address", imem_address, m_old_busy ? m_old_addr : m_pc);
        checkOutput("if_id_valid", {31'b0, if_id_valid}, {31'b0, q_valid});
        checkOutput("if_id_instruction", if_id_instruction, q_valid ? q_instr : NOP);
        if (q_valid)
            checkOutput("if_id_pc", if_id_pc, q_pc);
    endtask

    // One clock: check outputs (called at a falling edge), drive inputs,
    // advance the model, then move on to the next falling edge.
    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc,
                                 input logic rs, input logic [31:0] rd);
        compareAll();
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_resp   = rs;
        imem_rdata  = rd;
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_read"},  {31'b0, imem_read},   32'h0);
        checkOutput({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
        checkOutput({tag, "_instr"}, if_id_instruction,    NOP);
        checkOutput({tag, "_pc"},    if_id_pc,             32'h0);
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_resp   = 1'b0;
        imem_rdata  = 32'h0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        #1;
        checkOutput("first_addr", imem_address, 32'h60);
        checkOutput("first_read", {31'b0, imem_read}, 32'h1);

        // Back-to-back single-cycle responses.
        applyStimulus(0, 0, 0, 1, 32'h0000_0093);
        checkOutput("tp1_pc0", if_id_pc, 32'h60);
        checkOutput("tp1_in0", if_id_instruction, 32'h0000_0093);
        checkOutput("tp1_addr", imem_address, 32'h64);
        applyStimulus(0, 0, 0, 1, 32'h0010_0113);
        checkOutput("tp1_pc1", if_id_pc, 32'h64);
        checkOutput("tp1_in1", if_id_instruction, 32'h0010_0113);

        // Response for 0x68 arrives while stalled.
        applyStimulus(1, 0, 0, 1, 32'hAABB_CC13);
        checkOutput("tp2_read", {31'b0, imem_read}, 32'h0);
        checkOutput("tp2_hold", if_id_pc, 32'h64);
        applyStimulus(1, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("tp2_pc", if_id_pc, 32'h68);
        checkOutput("tp2_in", if_id_instruction, 32'hAABB_CC13);
        checkOutput("tp2_next", imem_address, 32'h6C);
        applyStimulus(0, 0, 0, 1, 32'h1111_1113);
        checkOutput("tp3_addr70", imem_address, 32'h70);

        // Redirect while the request for 0x70 is pending.
        applyStimulus(0, 1, 32'h200, 0, 32'h0);
        checkOutput("tp3_hold0", imem_address, 32'h70);
        checkOutput("tp3_flush", {31'b0, if_id_valid}, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("tp3_hold2", imem_address, 32'h70);
        applyStimulus(0, 0, 0, 1, 32'hDEAD_0013);
        checkOutput("tp3_target", imem_address, 32'h200);
        checkOutput("tp3_novalid", {31'b0, if_id_valid}, 32'h0);

        // Redirect, response and stall all in one cycle.
        applyStimulus(1, 1, 32'h300, 1, 32'h2222_2213);
        checkOutput("tp4_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("tp4_instr", if_id_instruction, NOP);
        checkOutput("tp4_addr", imem_address, 32'h300);
        checkOutput("tp4_read", {31'b0, imem_read}, 32'h1);

        // PC wraps past the top of the address space; low bits masked.
        applyStimulus(0, 1, 32'hFFFF_FFFF, 1, 32'h3333_3313);
        checkOutput("tp5_top", imem_address, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 1, 32'h4444_4413);
        checkOutput("tp5_wrap", imem_address, 32'h0);
        checkOutput("tp5_pc", if_id_pc, 32'hFFFF_FFFC);

        // Randomized traffic; memory only responds while a read is expected.
        for (int i = 0; i < 400; i++) begin
            logic s, r, rs;
            s  = ($urandom_range(0, 99) < 30);
            r  = ($urandom_range(0, 99) < 8);
            rs = !h_valid && ($urandom_range(0, 99) < 55);
            applyStimulus(s, r, $urandom, rs, $urandom);
        end

        // Reset asserted in the middle of a dropped request.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 32'h0);
        applyStimulus(0, 1, 32'h1000, 0, 32'h0);
        compareAll();
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("tp6_rst");
        checkOutput("tp6_addr", imem_address, 32'h60);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("tp6_restart", imem_address, 32'h60);
        checkOutput("tp6_read", {31'b0, imem_read}, 32'h1);
        applyStimulus(0, 0, 0, 1, 32'h5555_5513);
        applyStimulus(0, 0, 0, 0, 32'h0);
        compareAll();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
